// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU.
package cpu8_pkg;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_S = 3'd1,
    DECODE  = 3'd2,
    OPND_A  = 3'd3,
    OPND_S  = 3'd4,
    EXEC_A  = 3'd5,
    EXEC_S  = 3'd6,
    HALT    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_STA = 8'h02;
  localparam logic [7:0] OP_LDI = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JZ  = 8'h07;
  localparam logic [7:0] OP_JC  = 8'h08;
  localparam logic [7:0] OP_OUT = 8'h09;
  localparam logic [7:0] OP_IN  = 8'h0A;
  localparam logic [7:0] OP_HLT = 8'h0F;

  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  // Opcodes 01..0A carry an operand byte; everything else is single-byte.
  function automatic logic has_operand(input logic [7:0] op);
    return (op >= OP_LDA) && (op <= OP_IN);
  endfunction

endpackage

// File: rtl/cpu8_alu.sv
// Combinational ALU: pass-through, add with carry out, subtract with borrow.
module cpu8_alu
  import cpu8_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_m,
  input  alu_op_t    i_op,
  output logic [7:0] o_res,
  output logic       o_z,
  output logic       o_c
);

  logic [8:0] w_sum;
  logic [8:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_m};
  assign w_dif = {1'b0, i_a} - {1'b0, i_m};

  // Select result and carry/borrow by operation.
  always_comb begin
    o_res = i_m;
    o_c   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_res = w_sum[7:0];
        o_c   = w_sum[8];
      end
      ALU_SUB: begin
        o_res = w_dif[7:0];
        o_c   = w_dif[8];
      end
      default: ;
    endcase
    o_z = (o_res == '0);
  end

endmodule

// File: rtl/cpu8_core.sv
// 8-bit accumulator CPU mastering a shared tri-state data bus.
module cpu8_core
  import cpu8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = RESET_PC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] addr_bus,
  inout  wire  [7:0] bus,
  output logic       mem_clk,
  output logic       c_ri,
  output logic       c_ro,
  output logic       mem_io
);

  state_t     state, w_state_nxt;
  logic [7:0] pc_out, w_pc_nxt;
  logic [7:0] regi_out, w_ir_nxt;
  logic [7:0] r_opnd, w_opnd_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic       r_z, w_z_nxt;
  logic       r_c, w_c_nxt;

  logic       r_drv, w_drv;
  logic [7:0] r_wdata, w_wdata;
  logic [7:0] w_addr;
  logic       w_mclk, w_ri, w_ro, w_io;

  logic [7:0] w_bus_in;
  alu_op_t    w_alu_op;
  logic [7:0] w_alu_res;
  logic       w_alu_z, w_alu_c;

  assign bus      = r_drv ? r_wdata : 'z;
  assign w_bus_in = bus;

  assign w_alu_op = (regi_out == OP_ADD) ? ALU_ADD :
                    (regi_out == OP_SUB) ? ALU_SUB : ALU_PASS;

  cpu8_alu u_alu (
    .i_a   (r_acc),
    .i_m   (w_bus_in),
    .i_op  (w_alu_op),
    .o_res (w_alu_res),
    .o_z   (w_alu_z),
    .o_c   (w_alu_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt = state;
    w_pc_nxt    = pc_out;
    w_ir_nxt    = regi_out;
    w_opnd_nxt  = r_opnd;
    w_acc_nxt   = r_acc;
    w_z_nxt     = r_z;
    w_c_nxt     = r_c;
    case (state)
      FETCH_A: w_state_nxt = FETCH_S;
      FETCH_S: begin
        w_ir_nxt    = w_bus_in;
        w_pc_nxt    = pc_out + 8'd1;
        w_state_nxt = DECODE;
      end
      DECODE: begin
        if (regi_out == OP_HLT)        w_state_nxt = HALT;
        else if (has_operand(regi_out)) w_state_nxt = OPND_A;
        else                           w_state_nxt = FETCH_A;
      end
      OPND_A: w_state_nxt = OPND_S;
      OPND_S: begin
        w_opnd_nxt  = w_bus_in;
        w_pc_nxt    = pc_out + 8'd1;
        w_state_nxt = FETCH_A;
        case (regi_out)
          OP_LDI: begin
            w_acc_nxt = w_alu_res;
            w_z_nxt   = w_alu_z;
          end
          OP_JMP: w_pc_nxt = w_bus_in;
          OP_JZ:  if (r_z) w_pc_nxt = w_bus_in;
          OP_JC:  if (r_c) w_pc_nxt = w_bus_in;
          default: w_state_nxt = EXEC_A;
        endcase
      end
      EXEC_A: w_state_nxt = EXEC_S;
      EXEC_S: begin
        w_state_nxt = FETCH_A;
        case (regi_out)
          OP_LDA, OP_IN: begin
            w_acc_nxt = w_alu_res;
            w_z_nxt   = w_alu_z;
          end
          OP_ADD, OP_SUB: begin
            w_acc_nxt = w_alu_res;
            w_z_nxt   = w_alu_z;
            w_c_nxt   = w_alu_c;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = HALT;
    endcase
  end

  // Bus controls derived from the upcoming state so they are registered yet valid in that state.
  always_comb begin
    w_addr  = '0;
    w_mclk  = 1'b0;
    w_ri    = 1'b0;
    w_ro    = 1'b0;
    w_io    = 1'b0;
    w_drv   = 1'b0;
    w_wdata = '0;
    case (w_state_nxt)
      FETCH_A, FETCH_S, OPND_A, OPND_S: begin
        w_addr = w_pc_nxt;
        w_ro   = 1'b1;
        w_mclk = (w_state_nxt == FETCH_S) || (w_state_nxt == OPND_S);
      end
      EXEC_A, EXEC_S: begin
        w_addr = w_opnd_nxt;
        w_mclk = (w_state_nxt == EXEC_S);
        case (w_ir_nxt)
          OP_LDA, OP_ADD, OP_SUB: w_ro = 1'b1;
          OP_STA: begin
            w_ri    = 1'b1;
            w_drv   = 1'b1;
            w_wdata = w_acc_nxt;
          end
          OP_OUT: begin
            w_io    = 1'b1;
            w_drv   = 1'b1;
            w_wdata = w_acc_nxt;
          end
          OP_IN:   w_io = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH_A;
      pc_out   <= RESET_PC;
      regi_out <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      addr_bus <= '0;
      mem_clk  <= 1'b0;
      c_ri     <= 1'b0;
      c_ro     <= 1'b0;
      mem_io   <= 1'b0;
      r_drv    <= 1'b0;
      r_wdata  <= '0;
    end else begin
      state    <= w_state_nxt;
      pc_out   <= w_pc_nxt;
      regi_out <= w_ir_nxt;
      r_opnd   <= w_opnd_nxt;
      r_acc    <= w_acc_nxt;
      r_z      <= w_z_nxt;
      r_c      <= w_c_nxt;
      addr_bus <= w_addr;
      mem_clk  <= w_mclk;
      c_ri     <= w_ri;
      c_ro     <= w_ro;
      mem_io   <= w_io;
      r_drv    <= w_drv;
      r_wdata  <= w_wdata;
    end
  end

endmodule

// File: tb/tb_cpu8_core.sv
// Directed-vector bench for cpu8_core with a 256x8 RAM model and one input port.
module tb_cpu8_core;

  logic       clk;
  logic       reset;
  logic [7:0] addr_bus;
  wire  [7:0] bus;
  logic       mem_clk, c_ri, c_ro, mem_io;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       ld_go;

  int unsigned n_total;
  int unsigned n_bad;

  cpu8_core #(.RESET_PC(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr_bus (addr_bus),
    .bus      (bus),
    .mem_clk  (mem_clk),
    .c_ri     (c_ri),
    .c_ro     (c_ro),
    .mem_io   (mem_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: image load on ld_go, otherwise write on mem_clk rising edge.
  always @(posedge mem_clk or posedge ld_go) begin
    if (ld_go) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (c_ri && !mem_io) begin
      mem[addr_bus] <= bus;
    end
  end

  assign bus = (c_ro && !mem_io) ? mem[addr_bus] : 8'hzz;
  // Input peripheral at I/O address 01 always returns FF.
  assign bus = (mem_io && !c_ri && addr_bus == 8'h01) ? 8'hFF : 8'hzz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic commit_img();
    ld_go = 1'b1;
    #1;
    ld_go = 1'b0;
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    tick(3);
  endtask

  task automatic start(); // called at a negedge, with reset held low
    commit_img();
    reset = 1'b1;
  endtask

  logic       seen, bad_ro, found;
  logic [7:0] cap_addr, cap_bus;
  logic       cap_ri;

  initial begin
    n_total = 0;
    n_bad   = 0;
    ld_go   = 1'b0;
    reset   = 1'b0;
    clear_img();
    commit_img();

    // 1. reset state
    hold_reset();
    chk("rst_pc", 32'(dut.pc_out), 32'h00);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_strobes", {28'd0, c_ri, c_ro, mem_io, mem_clk}, 32'h0);
    chk("rst_bus_drv", 32'(dut.r_drv), 32'd0);
    chk("rst_addr", 32'(addr_bus), 32'h00);

    // 2. LDI 05; ADD 10; STA 11; HLT with M[10]=03
    clear_img();
    img[0] = 8'h03; img[1] = 8'h05; img[2] = 8'h04; img[3] = 8'h10;
    img[4] = 8'h02; img[5] = 8'h11; img[6] = 8'h0F; img[16] = 8'h03;
    start();
    tick(21);
    chk("prog_decode_hlt", 32'(dut.state), 32'd2);
    tick(1);
    chk("prog_halt", 32'(dut.state), 32'd7);
    tick(4);
    chk("prog_m11", 32'(mem[8'h11]), 32'h08);
    chk("prog_acc", 32'(dut.r_acc), 32'h08);
    chk("prog_c", 32'(dut.r_c), 32'd0);
    chk("halt_strobes", {28'd0, c_ri, c_ro, mem_io, mem_clk}, 32'h0);

    // 3. LDI 2A; OUT 00
    hold_reset();
    clear_img();
    img[0] = 8'h03; img[1] = 8'h2A; img[2] = 8'h09; img[3] = 8'h00; img[4] = 8'h0F;
    start();
    seen = 1'b0; cap_addr = '0; cap_bus = '0; cap_ri = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (mem_clk && mem_io && !seen) begin
        seen = 1'b1; cap_addr = addr_bus; cap_bus = bus; cap_ri = c_ri;
      end
    end
    chk("out_seen", 32'(seen), 32'd1);
    chk("out_addr", 32'(cap_addr), 32'h00);
    chk("out_bus", 32'(cap_bus), 32'h2A);
    chk("out_ri", 32'(cap_ri), 32'd0);
    chk("out_ram_kept", 32'(mem[0]), 32'h03);

    // 4. IN 01 with peripheral driving FF
    hold_reset();
    clear_img();
    img[0] = 8'h0A; img[1] = 8'h01; img[2] = 8'h0F;
    start();
    seen = 1'b0; bad_ro = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (mem_io) seen = 1'b1;
      if (mem_io && c_ro) bad_ro = 1'b1;
    end
    chk("in_seen", 32'(seen), 32'd1);
    chk("in_cro", 32'(bad_ro), 32'd0);
    chk("in_acc", 32'(dut.r_acc), 32'hFF);
    chk("in_z", 32'(dut.r_z), 32'd0);

    // 5a. LDI FF; ADD 20 [=01]; JC 40
    hold_reset();
    clear_img();
    img[0] = 8'h03; img[1] = 8'hFF; img[2] = 8'h04; img[3] = 8'h20;
    img[4] = 8'h08; img[5] = 8'h40; img[32] = 8'h01;
    start();
    tick(12);
    chk("add_acc", 32'(dut.r_acc), 32'h00);
    chk("add_zc", {30'd0, dut.r_z, dut.r_c}, 32'h3);
    tick(5);
    chk("jc_pc", 32'(dut.pc_out), 32'h40);

    // 5b. LDI 03; SUB 21 [=03]; JZ 50
    hold_reset();
    clear_img();
    img[0] = 8'h03; img[1] = 8'h03; img[2] = 8'h05; img[3] = 8'h21;
    img[4] = 8'h07; img[5] = 8'h50; img[33] = 8'h03;
    start();
    tick(12);
    chk("sub_zc", {30'd0, dut.r_z, dut.r_c}, 32'h2);
    tick(5);
    chk("jz_pc", 32'(dut.pc_out), 32'h50);

    // 6a. NOP at FF wraps to 00
    hold_reset();
    clear_img();
    img[0] = 8'h06; img[1] = 8'hFF; img[255] = 8'h00;
    start();
    tick(8);
    chk("wrap_pc", 32'(dut.pc_out), 32'h00);
    tick(1);
    chk("wrap_fetch_addr", {23'd0, c_ro, addr_bus}, {23'd0, 1'b1, 8'h00});

    // 6b. LDI at FF fetches its operand from 00
    hold_reset();
    clear_img();
    img[0] = 8'h06; img[1] = 8'hFF; img[255] = 8'h03;
    start();
    tick(10);
    chk("wrap_opnd_acc", 32'(dut.r_acc), 32'h06);
    chk("wrap_opnd_pc", 32'(dut.pc_out), 32'h01);

    // 6c. reset during EXEC_A of STA aborts the write
    hold_reset();
    clear_img();
    img[0] = 8'h03; img[1] = 8'h55; img[2] = 8'h02; img[3] = 8'h30; img[48] = 8'hAA;
    start();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (dut.state == 3'd5 && dut.regi_out == 8'h02) found = 1'b1;
    end
    chk("sta_exec_reached", 32'(found), 32'd1);
    reset = 1'b0;
    tick(2);
    chk("abort_ram", 32'(mem[8'h30]), 32'hAA);
    chk("abort_pc", 32'(dut.pc_out), 32'h00);
    chk("abort_state", 32'(dut.state), 32'd0);
    reset = 1'b1;
    tick(1);
    chk("restart_fetch", {23'd0, mem_clk, addr_bus}, {23'd0, 1'b1, 8'h00});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
